tcam_ctrl: RTL and testbench

- Front-end controller that shares one 16-entry x 16-bit ternary CAM (`tcam`) between two requesters: an entry-update (write) port and a key-search port.
- Arbitrates between the ports with starvation protection and sequences the TCAM's write/search cycles.
- Registers the search result and returns it over a valid/ready handshake.
- Sits between the classifier pipeline and the `tcam` instance.

---
 rtl/tcam_ctrl_if.sv | 39 +++
 rtl/tcam_ctrl.sv | 134 +++++++++++++
 tb/tb_tcam_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_ctrl_if.sv
// Requester-side bundle for tcam_ctrl: entry-write port, key-search port and search response.
// The master modport is the classifier pipeline; the slave modport is the controller.
interface tcam_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;

    logic              srch_valid;
    logic              srch_ready;
    logic [DATA_W-1:0] srch_key;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask,
        input  wr_ready,
        output srch_valid, srch_key,
        input  srch_ready,
        input  rsp_valid, rsp_hit, rsp_addr,
        output rsp_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask,
        output wr_ready,
        input  srch_valid, srch_key,
        output srch_ready,
        output rsp_valid, rsp_hit, rsp_addr,
        input  rsp_ready
    );
endinterface

// File: rtl/tcam_ctrl.sv
// Shares one ternary CAM between an entry-write port and a key-search port, with
// write-priority arbitration bounded by a starvation counter and a registered search response.
module tcam_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    tcam_ctrl_if.slave             bus,
    output logic [2**ADDR_W-1:0]   entry_valid,
    output logic [DATA_W-1:0]      tcam_data,
    output logic [DATA_W-1:0]      tcam_dontcare,
    output logic [ADDR_W-1:0]      tcam_write_address,
    output logic                   tcam_write_readN,
    output logic                   tcam_resetN,
    input  logic [ADDR_W-1:0]      tcam_found_address,
    input  logic                   tcam_found_any
);
    localparam int unsigned NUM_ENTRIES = 2**ADDR_W;
    localparam int unsigned CNT_W       = $clog2(STARVE_LIMIT + 1) > 0 ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWrite, StSearch, StResp} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       starve_q, starve_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [DATA_W-1:0]      dontcare_q, dontcare_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [ADDR_W-1:0]      rsp_addr_q, rsp_addr_d;
    logic [NUM_ENTRIES-1:0] entry_valid_q, entry_valid_d;
    logic                   tcam_resetn_q;

    logic starved;
    logic grant_wr;
    logic grant_srch;

    // Writes win ties until the pending search has been passed over STARVE_LIMIT times.
    always_comb begin
        starved    = (starve_q == CNT_W'(STARVE_LIMIT));
        grant_wr   = !reset && (state_q == StIdle) && bus.wr_valid &&
                     !(bus.srch_valid && starved);
        grant_srch = !reset && (state_q == StIdle) && bus.srch_valid && !grant_wr;
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        data_d        = data_q;
        dontcare_d    = dontcare_q;
        waddr_d       = waddr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_addr_d    = rsp_addr_q;
        entry_valid_d = entry_valid_q;

        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    data_d     = bus.wr_data;
                    dontcare_d = bus.wr_mask;
                    waddr_d    = bus.wr_addr;
                    state_d    = StWrite;
                    if (bus.srch_valid && !starved) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (grant_srch) begin
                    data_d     = bus.srch_key;
                    dontcare_d = '0;
                    starve_d   = '0;
                    state_d    = StSearch;
                end
            end
            StWrite: begin
                entry_valid_d[waddr_q] = 1'b1;
                state_d                = StIdle;
            end
            StSearch: begin
                rsp_hit_d   = tcam_found_any;
                rsp_addr_d  = tcam_found_any ? tcam_found_address : '0;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            data_q        <= '0;
            dontcare_q    <= '0;
            waddr_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_addr_q    <= '0;
            entry_valid_q <= '0;
            tcam_resetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            data_q        <= data_d;
            dontcare_q    <= dontcare_d;
            waddr_q       <= waddr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_addr_q    <= rsp_addr_d;
            entry_valid_q <= entry_valid_d;
            tcam_resetn_q <= 1'b1;
        end
    end

    assign bus.wr_ready   = grant_wr;
    assign bus.srch_ready = grant_srch;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_addr   = rsp_addr_q;

    assign entry_valid        = entry_valid_q;
    assign tcam_data          = data_q;
    assign tcam_dontcare      = dontcare_q;
    assign tcam_write_address = waddr_q;
    assign tcam_write_readN   = (state_q == StWrite);
    assign tcam_resetN        = tcam_resetn_q;
endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed bench for tcam_ctrl with a behavioural 16x16 ternary CAM attached to the tcam_* side.
module tb_tcam_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] entry_valid;
    logic [15:0] tcam_data;
    logic [15:0] tcam_dontcare;
    logic [3:0]  tcam_write_address;
    logic        tcam_write_readN;
    logic        tcam_resetN;
    logic [3:0]  tcam_found_address;
    logic        tcam_found_any;

    int checks     = 0;
    int failures   = 0;
    int wrn_viol   = 0;
    int both_viol  = 0;
    int wrn_cycles = 0;
    logic acc_q    = 1'b0;
    logic wrn_prev = 1'b0;

    tcam_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    tcam_ctrl #(.DATA_W(16), .ADDR_W(4), .STARVE_LIMIT(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .entry_valid        (entry_valid),
        .tcam_data          (tcam_data),
        .tcam_dontcare      (tcam_dontcare),
        .tcam_write_address (tcam_write_address),
        .tcam_write_readN   (tcam_write_readN),
        .tcam_resetN        (tcam_resetN),
        .tcam_found_address (tcam_found_address),
        .tcam_found_any     (tcam_found_any)
    );

    always #5 clk = ~clk;

    // Ternary CAM model: lowest matching valid entry wins; miss drives a nonzero address.
    logic [15:0] m_data [16];
    logic [15:0] m_mask [16];
    logic [15:0] m_vld = '0;

    always @(posedge clk) begin
        if (!tcam_resetN) begin
            m_vld <= '0;
        end else if (tcam_write_readN) begin
            m_data[tcam_write_address] <= tcam_data;
            m_mask[tcam_write_address] <= tcam_dontcare;
            m_vld[tcam_write_address]  <= 1'b1;
        end
    end

    always_comb begin
        tcam_found_any     = 1'b0;
        tcam_found_address = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            if (m_vld[i] && (((tcam_data ^ m_data[i]) & ~m_mask[i]) == 16'h0)) begin
                tcam_found_any     = 1'b1;
                tcam_found_address = 4'(i);
            end
        end
    end

    // Write strobe must appear exactly in the cycle after each write accept.
    always @(posedge clk) acc_q <= !reset && bus.wr_valid && bus.wr_ready;

    always @(negedge clk) begin
        if (tcam_write_readN !== acc_q) wrn_viol <= wrn_viol + 1;
        if (tcam_write_readN && wrn_prev) wrn_viol <= wrn_viol + 1;
        if (bus.wr_ready && bus.srch_ready) both_viol <= both_viol + 1;
        if (tcam_write_readN) wrn_cycles <= wrn_cycles + 1;
        wrn_prev <= tcam_write_readN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_mask  = m;
        #1;
        while (!bus.wr_ready && n < 10) begin
            tick();
            n++;
        end
        check("wr_ready", 32'(bus.wr_ready), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        check("wr_strobe", 32'(tcam_write_readN), 32'd1);
        check("wr_address", 32'(tcam_write_address), 32'(a));
        tick();
    endtask

    task automatic do_search(input logic [15:0] key, input logic exp_hit, input logic [3:0] exp_addr);
        int n = 0;
        bus.srch_valid = 1'b1;
        bus.srch_key   = key;
        #1;
        while (!bus.srch_ready && n < 10) begin
            tick();
            n++;
        end
        check("srch_ready", 32'(bus.srch_ready), 32'd1);
        tick();
        bus.srch_valid = 1'b0;
        check("rsp_early", 32'(bus.rsp_valid), 32'd0);
        check("srch_strobe", 32'(tcam_write_readN), 32'd0);
        check("srch_dontcare", 32'(tcam_dontcare), 32'd0);
        tick();
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_hit", 32'(bus.rsp_hit), 32'(exp_hit));
        check("rsp_addr", 32'(bus.rsp_addr), 32'(exp_addr));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  seq;
        logic [3:0]  wa;
        int          g;

        reset          = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = 4'd0;
        bus.wr_data    = 16'h0;
        bus.wr_mask    = 16'h0;
        bus.srch_valid = 1'b1;
        bus.srch_key   = 16'h0;
        bus.rsp_ready  = 1'b0;
        tick();
        tick();
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_srch_ready", 32'(bus.srch_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_entry_valid", 32'(entry_valid), 32'd0);
        check("rst_tcam_resetN", 32'(tcam_resetN), 32'd0);
        check("rst_write_readN", 32'(tcam_write_readN), 32'd0);
        check("rst_tcam_data", 32'(tcam_data), 32'd0);
        bus.wr_valid   = 1'b0;
        bus.srch_valid = 1'b0;
        reset          = 1'b0;
        tick();
        check("tcam_resetN_release", 32'(tcam_resetN), 32'd1);

        // Entry 14 checks only the unmasked bits, which 0xE96C matches.
        do_write(4'd14, 16'h6EEA, 16'h8787);
        do_search(16'hE96C, 1'b1, 4'd14);
        check("entry_valid_14", 32'(entry_valid), 32'h4000);

        // Entry 8 only cares about bit 14 being 0.
        do_write(4'd8, 16'h8133, 16'hBFFF);
        do_search(16'h92B5, 1'b1, 4'd8);
        do_search(16'h0000, 1'b1, 4'd8);
        do_search(16'h4000, 1'b0, 4'd0);
        check("entry_valid_8_14", 32'(entry_valid), 32'h4100);

        // Both ports busy: expect W W W S W W W S (bit set = search grant).
        seq            = '0;
        g              = 0;
        wa             = 4'd0;
        bus.rsp_ready  = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_addr    = wa;
        bus.wr_data    = 16'h1000;
        bus.wr_mask    = 16'h0;
        bus.srch_valid = 1'b1;
        bus.srch_key   = 16'hE96C;
        for (int c = 0; c < 60 && g < 8; c++) begin
            #1;
            if (bus.wr_ready) begin
                tick();
                g++;
                wa          = wa + 4'd1;
                bus.wr_addr = wa;
                bus.wr_data = 16'h1000 | 16'(wa);
            end else if (bus.srch_ready) begin
                seq[g] = 1'b1;
                tick();
                g++;
            end else begin
                tick();
            end
        end
        bus.wr_valid   = 1'b0;
        bus.srch_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.rsp_ready = 1'b0;
        check("starve_grants", 32'(g), 32'd8);
        check("starve_seq", 32'(seq), 32'h88);
        check("starve_entries", 32'(entry_valid), 32'h413F);

        // Response held while the consumer stalls; no grants meanwhile.
        bus.srch_valid = 1'b1;
        bus.srch_key   = 16'h92B5;
        #1;
        check("hold_srch_ready", 32'(bus.srch_ready), 32'd1);
        tick();
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd9;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_hit", 32'(bus.rsp_hit), 32'd1);
            check("hold_rsp_addr", 32'(bus.rsp_addr), 32'd8);
            check("hold_wr_ready", 32'(bus.wr_ready), 32'd0);
            check("hold_srch_ready", 32'(bus.srch_ready), 32'd0);
            tick();
        end
        bus.rsp_ready  = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.srch_valid = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
        check("hold_release", 32'(bus.rsp_valid), 32'd0);
        bus.wr_valid = 1'b1;
        #1;
        check("idle_after_rsp", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b0;
        #1;

        // Reset while SEARCH is in flight drops the result and clears the table.
        bus.srch_valid = 1'b1;
        bus.srch_key   = 16'hE96C;
        #1;
        check("mid_srch_ready", 32'(bus.srch_ready), 32'd1);
        tick();
        bus.srch_valid = 1'b0;
        reset          = 1'b1;
        tick();
        check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_entry_valid", 32'(entry_valid), 32'd0);
        check("mid_tcam_resetN", 32'(tcam_resetN), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_tcam_resetN_up", 32'(tcam_resetN), 32'd1);
        do_search(16'hE96C, 1'b0, 4'd0);

        tick();
        check("wrn_monitor", 32'(wrn_viol), 32'd0);
        check("ready_exclusive", 32'(both_viol), 32'd0);
        check("wrn_cycles", 32'(wrn_cycles), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
